// File: rtl/id_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module : id_pipe_pkg
// Shared decode constants, ALU opcode bus type and immediate-select encoding.
// Rev    : 1.0
// ============================================================================
package id_pipe_pkg;

    localparam logic [4:0] OP_NOP    = 5'b00001;
    localparam logic [4:0] OP_ADDIU  = 5'b01000;
    localparam logic [4:0] OP_ADDIU3 = 5'b01001;
    localparam logic [4:0] OP_LI     = 5'b01101;
    localparam logic [4:0] OP_RRR    = 5'b11100;

    localparam logic [1:0] FUNC_ADDU = 2'b01;
    localparam logic [1:0] FUNC_SUBU = 2'b11;

    typedef logic [3:0] AluOpBus;
    localparam AluOpBus ALU_NOP = 4'd0;
    localparam AluOpBus ALU_ADD = 4'd1;
    localparam AluOpBus ALU_SUB = 4'd2;

    localparam logic [15:0] ZeroWord = 16'h0000;
    localparam logic        Enable   = 1'b1;
    localparam logic        Disable  = 1'b0;

    typedef enum logic [1:0] {
        IMM_NONE  = 2'd0,
        IMM_SEXT5 = 2'd1,
        IMM_SEXT8 = 2'd2,
        IMM_ZEXT8 = 2'd3
    } imm_sel_e;

endpackage
`default_nettype wire

// File: rtl/id_pipe_if.sv
`default_nettype none
// ============================================================================
// Module : id_pipe_if
// ID-stage bus: fetch input, register-file read port, EX/MEM write-back info,
// stall/flush control and the registered ID/EX outputs.
// Rev    : 1.0
// ============================================================================
interface id_pipe_if
    import id_pipe_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3
);
    logic                  instValid_i;
    logic [15:0]           instAddr_i;
    logic [15:0]           inst_i;

    logic [DATA_W-1:0]     reg1Data_i;
    logic [DATA_W-1:0]     reg2Data_i;
    logic                  reg1Enable_o;
    logic                  reg2Enable_o;
    logic [REG_ADDR_W-1:0] reg1Addr_o;
    logic [REG_ADDR_W-1:0] reg2Addr_o;

    logic                  exWReg_i;
    logic [REG_ADDR_W-1:0] exWRegAddr_i;
    logic [DATA_W-1:0]     exWData_i;
    logic                  exIsLoad_i;
    logic                  memWReg_i;
    logic [REG_ADDR_W-1:0] memWRegAddr_i;
    logic [DATA_W-1:0]     memWData_i;

    logic                  stall_i;
    logic                  flush_i;
    logic                  stallReq_o;

    logic                  valid_o;
    logic [15:0]           instAddr_o;
    logic [DATA_W-1:0]     operand1_o;
    logic [DATA_W-1:0]     operand2_o;
    AluOpBus               aluOp_o;
    logic                  wReg_o;
    logic [REG_ADDR_W-1:0] wRegAddr_o;

    // master: the decode stage itself; slave: the surrounding pipeline
    modport master (
        input  instValid_i, instAddr_i, inst_i, reg1Data_i, reg2Data_i,
               exWReg_i, exWRegAddr_i, exWData_i, exIsLoad_i,
               memWReg_i, memWRegAddr_i, memWData_i, stall_i, flush_i,
        output reg1Enable_o, reg2Enable_o, reg1Addr_o, reg2Addr_o, stallReq_o,
               valid_o, instAddr_o, operand1_o, operand2_o, aluOp_o, wReg_o, wRegAddr_o
    );

    modport slave (
        output instValid_i, instAddr_i, inst_i, reg1Data_i, reg2Data_i,
               exWReg_i, exWRegAddr_i, exWData_i, exIsLoad_i,
               memWReg_i, memWRegAddr_i, memWData_i, stall_i, flush_i,
        input  reg1Enable_o, reg2Enable_o, reg1Addr_o, reg2Addr_o, stallReq_o,
               valid_o, instAddr_o, operand1_o, operand2_o, aluOp_o, wReg_o, wRegAddr_o
    );
endinterface
`default_nettype wire

// File: rtl/id_fwd_mux.sv
`default_nettype none
// ============================================================================
// Module : id_fwd_mux
// Operand source select for one read port: EX result, then MEM result, then RF.
// Rev    : 1.0
// ============================================================================
module id_fwd_mux
    import id_pipe_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3
) (
    input  wire logic                  i_rd_en,
    input  wire logic [REG_ADDR_W-1:0] i_rd_addr,
    input  wire logic [DATA_W-1:0]     i_rf_data,
    input  wire logic                  i_ex_wreg,
    input  wire logic [REG_ADDR_W-1:0] i_ex_addr,
    input  wire logic [DATA_W-1:0]     i_ex_data,
    input  wire logic                  i_mem_wreg,
    input  wire logic [REG_ADDR_W-1:0] i_mem_addr,
    input  wire logic [DATA_W-1:0]     i_mem_data,
    output logic      [DATA_W-1:0]     o_data
);
    always_comb begin
        o_data = i_rf_data;
        if ((i_rd_en == Enable) && (i_ex_wreg == Enable) && (i_ex_addr == i_rd_addr)) begin
            o_data = i_ex_data;
        end else if ((i_rd_en == Enable) && (i_mem_wreg == Enable) && (i_mem_addr == i_rd_addr)) begin
            o_data = i_mem_data;
        end
    end
endmodule
`default_nettype wire

// File: rtl/id_pipe.sv
`default_nettype none
// ============================================================================
// Module : id_pipe
// Decode stage: decodes the ADDIU3/ADDIU/LI/ADDU/SUBU subset, resolves
// operands and drives the registered ID/EX bus.
// Config : ID_FWD_EN defined -> EX/MEM forwarding, stall only on load-use;
//          undefined -> no forwarding, any pending EX/MEM write hazard stalls.
// Rev    : 1.0
// ============================================================================
module id_pipe
    import id_pipe_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3
) (
    input  wire logic clk,
    input  wire logic rst,
    id_pipe_if.master bus
);
    logic [15:0]           w_inst;
    logic [4:0]            w_opcode;
    logic [1:0]            w_func;
    logic [REG_ADDR_W-1:0] w_rx;
    logic [REG_ADDR_W-1:0] w_ry;
    logic [REG_ADDR_W-1:0] w_rz;

    assign w_inst   = bus.inst_i;
    assign w_opcode = w_inst[15:11];
    assign w_func   = w_inst[1:0];
    assign w_rx     = REG_ADDR_W'(w_inst[10:8]);
    assign w_ry     = REG_ADDR_W'(w_inst[7:5]);
    assign w_rz     = REG_ADDR_W'(w_inst[4:2]);

    logic                  w_reg1_en;
    logic                  w_reg2_en;
    logic [REG_ADDR_W-1:0] w_reg1_addr;
    logic [REG_ADDR_W-1:0] w_reg2_addr;
    logic                  w_wreg;
    logic [REG_ADDR_W-1:0] w_waddr;
    AluOpBus               w_alu_op;
    imm_sel_e              w_imm_sel;

    always_comb begin
        w_reg1_en   = Disable;
        w_reg2_en   = Disable;
        w_reg1_addr = '0;
        w_reg2_addr = '0;
        w_wreg      = Disable;
        w_waddr     = '0;
        w_alu_op    = ALU_NOP;
        w_imm_sel   = IMM_NONE;
        if (bus.instValid_i) begin
            case (w_opcode)
                OP_ADDIU3: begin
                    w_reg1_en   = Enable;
                    w_reg1_addr = w_rx;
                    w_wreg      = Enable;
                    w_waddr     = w_ry;
                    w_alu_op    = ALU_ADD;
                    w_imm_sel   = IMM_SEXT5;
                end
                OP_ADDIU: begin
                    w_reg1_en   = Enable;
                    w_reg1_addr = w_rx;
                    w_wreg      = Enable;
                    w_waddr     = w_rx;
                    w_alu_op    = ALU_ADD;
                    w_imm_sel   = IMM_SEXT8;
                end
                OP_LI: begin
                    w_wreg      = Enable;
                    w_waddr     = w_rx;
                    w_alu_op    = ALU_ADD;
                    w_imm_sel   = IMM_ZEXT8;
                end
                OP_RRR: begin
                    if ((w_func == FUNC_ADDU) || (w_func == FUNC_SUBU)) begin
                        w_reg1_en   = Enable;
                        w_reg1_addr = w_rx;
                        w_reg2_en   = Enable;
                        w_reg2_addr = w_ry;
                        w_wreg      = Enable;
                        w_waddr     = w_rz;
                        w_alu_op    = (w_func == FUNC_SUBU) ? ALU_SUB : ALU_ADD;
                    end
                end
                default: ;
            endcase
        end
    end

    logic [DATA_W-1:0] w_imm;

    always_comb begin
        w_imm = '0;
        case (w_imm_sel)
            IMM_SEXT5: w_imm = {{(DATA_W-5){w_inst[4]}}, w_inst[4:0]};
            IMM_SEXT8: w_imm = {{(DATA_W-8){w_inst[7]}}, w_inst[7:0]};
            IMM_ZEXT8: w_imm = {{(DATA_W-8){1'b0}}, w_inst[7:0]};
            default:   w_imm = '0;
        endcase
    end

    assign bus.reg1Enable_o = w_reg1_en;
    assign bus.reg2Enable_o = w_reg2_en;
    assign bus.reg1Addr_o   = w_reg1_addr;
    assign bus.reg2Addr_o   = w_reg2_addr;

    logic              w_ex_hit1;
    logic              w_ex_hit2;
    logic              w_hazard;
    logic [DATA_W-1:0] w_src1;
    logic [DATA_W-1:0] w_src2;

    assign w_ex_hit1 = w_reg1_en && bus.exWReg_i && (bus.exWRegAddr_i == w_reg1_addr);
    assign w_ex_hit2 = w_reg2_en && bus.exWReg_i && (bus.exWRegAddr_i == w_reg2_addr);

`ifdef ID_FWD_EN
    id_fwd_mux #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_fwd1 (
        .i_rd_en   (w_reg1_en),
        .i_rd_addr (w_reg1_addr),
        .i_rf_data (bus.reg1Data_i),
        .i_ex_wreg (bus.exWReg_i),
        .i_ex_addr (bus.exWRegAddr_i),
        .i_ex_data (bus.exWData_i),
        .i_mem_wreg(bus.memWReg_i),
        .i_mem_addr(bus.memWRegAddr_i),
        .i_mem_data(bus.memWData_i),
        .o_data    (w_src1)
    );

    id_fwd_mux #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_fwd2 (
        .i_rd_en   (w_reg2_en),
        .i_rd_addr (w_reg2_addr),
        .i_rf_data (bus.reg2Data_i),
        .i_ex_wreg (bus.exWReg_i),
        .i_ex_addr (bus.exWRegAddr_i),
        .i_ex_data (bus.exWData_i),
        .i_mem_wreg(bus.memWReg_i),
        .i_mem_addr(bus.memWRegAddr_i),
        .i_mem_data(bus.memWData_i),
        .o_data    (w_src2)
    );

    // A load's data only exists after MEM, so it cannot be forwarded from EX
    assign w_hazard = bus.exIsLoad_i && (w_ex_hit1 || w_ex_hit2);
`else
    logic w_mem_hit1;
    logic w_mem_hit2;
    logic w_unused;

    assign w_mem_hit1 = w_reg1_en && bus.memWReg_i && (bus.memWRegAddr_i == w_reg1_addr);
    assign w_mem_hit2 = w_reg2_en && bus.memWReg_i && (bus.memWRegAddr_i == w_reg2_addr);
    assign w_src1     = bus.reg1Data_i;
    assign w_src2     = bus.reg2Data_i;
    assign w_hazard   = w_ex_hit1 || w_ex_hit2 || w_mem_hit1 || w_mem_hit2;
    assign w_unused   = ^{bus.exIsLoad_i, bus.exWData_i, bus.memWData_i};
`endif

    logic w_stall_req;
    assign w_stall_req    = bus.instValid_i && !bus.flush_i && w_hazard;
    assign bus.stallReq_o = w_stall_req;

    logic [DATA_W-1:0] w_op1;
    logic [DATA_W-1:0] w_op2;

    // LI carries its immediate in operand 1; register-immediate forms in operand 2
    assign w_op1 = w_reg1_en ? w_src1 : w_imm;
    assign w_op2 = w_reg2_en ? w_src2 : (w_reg1_en ? w_imm : '0);

    logic                  r_valid;
    logic [15:0]           r_inst_addr;
    logic [DATA_W-1:0]     r_op1;
    logic [DATA_W-1:0]     r_op2;
    AluOpBus               r_alu_op;
    logic                  r_wreg;
    logic [REG_ADDR_W-1:0] r_waddr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid     <= Disable;
            r_inst_addr <= ZeroWord;
            r_op1       <= DATA_W'(ZeroWord);
            r_op2       <= DATA_W'(ZeroWord);
            r_alu_op    <= ALU_NOP;
            r_wreg      <= Disable;
            r_waddr     <= '0;
        end else if (bus.flush_i || (!bus.stall_i && w_stall_req)) begin
            r_valid     <= Disable;
            r_inst_addr <= ZeroWord;
            r_op1       <= DATA_W'(ZeroWord);
            r_op2       <= DATA_W'(ZeroWord);
            r_alu_op    <= ALU_NOP;
            r_wreg      <= Disable;
            r_waddr     <= '0;
        end else if (!bus.stall_i) begin
            r_valid     <= bus.instValid_i;
            r_inst_addr <= bus.instAddr_i;
            r_op1       <= w_op1;
            r_op2       <= w_op2;
            r_alu_op    <= w_alu_op;
            r_wreg      <= w_wreg;
            r_waddr     <= w_waddr;
        end
    end

    assign bus.valid_o    = r_valid;
    assign bus.instAddr_o = r_inst_addr;
    assign bus.operand1_o = r_op1;
    assign bus.operand2_o = r_op2;
    assign bus.aluOp_o    = r_alu_op;
    assign bus.wReg_o     = r_wreg;
    assign bus.wRegAddr_o = r_waddr;
endmodule
`default_nettype wire

// File: tb/tb_id_pipe.sv
`default_nettype none
// ============================================================================
// Module : tb_id_pipe
// Directed and randomized bench for id_pipe against a behavioural decode model.
// Rev    : 1.0
// ============================================================================
module tb_id_pipe;
    import id_pipe_pkg::*;

    typedef struct packed {
        logic        valid;
        logic [15:0] addr;
        logic [15:0] op1;
        logic [15:0] op2;
        AluOpBus     alu;
        logic        wreg;
        logic [2:0]  waddr;
    } out_t;

    logic        clk;
    logic        rst;
    logic [15:0] rf [8];
    out_t        exp_q;
    int          checks   = 0;
    int          failures = 0;

    id_pipe_if #(.DATA_W(16), .REG_ADDR_W(3)) bus ();

    id_pipe #(.DATA_W(16), .REG_ADDR_W(3)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    assign bus.reg1Data_i = rf[bus.reg1Addr_o];
    assign bus.reg2Data_i = rf[bus.reg2Addr_o];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] sx(input int v, input int bits);
        int r;
        r = (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
        return 16'(r);
    endfunction

    // value a reader of register a should see this cycle
    function automatic logic [15:0] rd(input int a);
`ifdef ID_FWD_EN
        if (bus.exWReg_i && int'(bus.exWRegAddr_i) == a) return bus.exWData_i;
        if (bus.memWReg_i && int'(bus.memWRegAddr_i) == a) return bus.memWData_i;
`endif
        return rf[a];
    endfunction

    function automatic bit haz(input int a);
`ifdef ID_FWD_EN
        return bus.exWReg_i && bus.exIsLoad_i && (int'(bus.exWRegAddr_i) == a);
`else
        return (bus.exWReg_i && int'(bus.exWRegAddr_i) == a) ||
               (bus.memWReg_i && int'(bus.memWRegAddr_i) == a);
`endif
    endfunction

    function automatic void decode(input logic [15:0] ins, input logic v, input logic [15:0] pc,
                                   output bit r1en, output int r1, output bit r2en, output int r2,
                                   output out_t o);
        int rx, ry, rz;
        rx = int'(ins[10:8]);
        ry = int'(ins[7:5]);
        rz = int'(ins[4:2]);
        r1en = 0; r2en = 0; r1 = 0; r2 = 0;
        o = '0;
        o.valid = v;
        o.addr  = pc;
        if (!v) return;
        case (ins[15:11])
            5'b01001: begin // ADDIU3 ry = rx + sext(imm5)
                r1en = 1; r1 = rx;
                o.op1 = rd(rx); o.op2 = sx(int'(ins[4:0]), 5);
                o.alu = ALU_ADD; o.wreg = 1; o.waddr = 3'(ry);
            end
            5'b01000: begin // ADDIU rx = rx + sext(imm8)
                r1en = 1; r1 = rx;
                o.op1 = rd(rx); o.op2 = sx(int'(ins[7:0]), 8);
                o.alu = ALU_ADD; o.wreg = 1; o.waddr = 3'(rx);
            end
            5'b01101: begin // LI rx = zext(imm8)
                o.op1 = 16'(int'(ins[7:0]));
                o.alu = ALU_ADD; o.wreg = 1; o.waddr = 3'(rx);
            end
            5'b11100: begin
                if (ins[1:0] == 2'b01 || ins[1:0] == 2'b11) begin
                    r1en = 1; r1 = rx; r2en = 1; r2 = ry;
                    o.op1 = rd(rx); o.op2 = rd(ry);
                    o.alu = (ins[1:0] == 2'b11) ? ALU_SUB : ALU_ADD;
                    o.wreg = 1; o.waddr = 3'(rz);
                end
            end
            default: ;
        endcase
    endfunction

    task automatic check_out(input string tag);
        chk({tag, ".valid"}, 32'(bus.valid_o), 32'(exp_q.valid));
        if (exp_q.valid) chk({tag, ".addr"}, 32'(bus.instAddr_o), 32'(exp_q.addr));
        chk({tag, ".op1"},   32'(bus.operand1_o), 32'(exp_q.op1));
        chk({tag, ".op2"},   32'(bus.operand2_o), 32'(exp_q.op2));
        chk({tag, ".alu"},   32'(bus.aluOp_o),    32'(exp_q.alu));
        chk({tag, ".wreg"},  32'(bus.wReg_o),     32'(exp_q.wreg));
        chk({tag, ".waddr"}, 32'(bus.wRegAddr_o), 32'(exp_q.waddr));
    endtask

    task automatic step(input string tag);
        bit   r1en, r2en, hz, st;
        int   r1, r2;
        out_t d;
        #1;
        decode(bus.inst_i, bus.instValid_i, bus.instAddr_i, r1en, r1, r2en, r2, d);
        hz = 0;
        if (r1en) hz = hz | haz(r1);
        if (r2en) hz = hz | haz(r2);
        st = bus.instValid_i && !bus.flush_i && hz;
        chk({tag, ".r1en"}, 32'(bus.reg1Enable_o), 32'(r1en));
        if (r1en) chk({tag, ".r1addr"}, 32'(bus.reg1Addr_o), 32'(r1));
        chk({tag, ".r2en"}, 32'(bus.reg2Enable_o), 32'(r2en));
        if (r2en) chk({tag, ".r2addr"}, 32'(bus.reg2Addr_o), 32'(r2));
        chk({tag, ".stallreq"}, 32'(bus.stallReq_o), 32'(st));
        if (bus.flush_i)       exp_q = '0;
        else if (!bus.stall_i) exp_q = st ? '0 : d;
        @(posedge clk);
        #1;
        check_out(tag);
    endtask

    task automatic set_inst(input logic v, input logic [15:0] ins, input logic [15:0] pc);
        bus.instValid_i = v; bus.inst_i = ins; bus.instAddr_i = pc;
    endtask

    task automatic set_ex(input logic w, input logic [2:0] a, input logic [15:0] d, input logic ld);
        bus.exWReg_i = w; bus.exWRegAddr_i = a; bus.exWData_i = d; bus.exIsLoad_i = ld;
    endtask

    task automatic set_mem(input logic w, input logic [2:0] a, input logic [15:0] d);
        bus.memWReg_i = w; bus.memWRegAddr_i = a; bus.memWData_i = d;
    endtask

    task automatic idle();
        set_inst(1'b0, 16'h0800, 16'h0000);
        set_ex(1'b0, 3'd0, 16'h0, 1'b0);
        set_mem(1'b0, 3'd0, 16'h0);
        bus.stall_i = 1'b0; bus.flush_i = 1'b0;
    endtask

    task automatic mid_reset();
        #2 rst = 1'b0;
        #1;
        exp_q = '0;
        check_out("midreset.async");
        chk("midreset.addr", 32'(bus.instAddr_o), 32'h0);
        @(posedge clk);
        #1;
        check_out("midreset.held");
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [15:0] ins;
        for (int i = 0; i < 8; i++) rf[i] = 16'(16'h1000 + i * 16'h0101);
        rf[2] = 16'h0003;
        rst = 1'b1;
        idle();
        exp_q = '0;
        #1 rst = 1'b0;
        #1;
        check_out("reset");
        chk("reset.addr", 32'(bus.instAddr_o), 32'h0);
        @(posedge clk); #1;
        check_out("reset.edge");
        @(negedge clk);
        rst = 1'b1;

        // ADDIU3 R2 + 5 -> R1
        set_inst(1'b1, 16'h4A25, 16'h0100);
        step("addiu3");
        chk("addiu3.valid_lit", 32'(bus.valid_o), 32'h1);
        chk("addiu3.op1_lit",   32'(bus.operand1_o), 32'h0003);
        chk("addiu3.op2_lit",   32'(bus.operand2_o), 32'h0005);
        chk("addiu3.alu_lit",   32'(bus.aluOp_o), 32'(ALU_ADD));
        chk("addiu3.waddr_lit", 32'(bus.wRegAddr_o), 32'h1);

        // ADDIU3 with negative immediate
        set_inst(1'b1, 16'h4A3F, 16'h0102);
        step("addiu3neg");
        chk("addiu3neg.op2_lit", 32'(bus.operand2_o), 32'hFFFF);

        // LI zero-extends
        set_inst(1'b1, 16'h6DFF, 16'h0104);
        step("li");
        chk("li.op1_lit", 32'(bus.operand1_o), 32'h00FF);
        chk("li.waddr_lit", 32'(bus.wRegAddr_o), 32'h5);

        // ADDU R1,R2->R3 with EX and MEM both writing R1, then MEM only
        set_inst(1'b1, 16'hE14D, 16'h0106);
        set_ex(1'b1, 3'd1, 16'h1111, 1'b0);
        set_mem(1'b1, 3'd1, 16'h2222);
        step("fwd.exmem");
`ifdef ID_FWD_EN
        chk("fwd.exmem.op1_lit", 32'(bus.operand1_o), 32'h1111);
`else
        chk("fwd.exmem.bubble_lit", 32'(bus.valid_o), 32'h0);
`endif
        set_ex(1'b0, 3'd0, 16'h0, 1'b0);
        step("fwd.mem");
`ifdef ID_FWD_EN
        chk("fwd.mem.op1_lit", 32'(bus.operand1_o), 32'h2222);
`else
        chk("fwd.mem.bubble_lit", 32'(bus.valid_o), 32'h0);
`endif
        set_mem(1'b0, 3'd0, 16'h0);
        step("fwd.none");
        chk("fwd.none.valid_lit", 32'(bus.valid_o), 32'h1);

        // Load-use on R2 followed by MEM forward
        set_inst(1'b1, 16'h4A25, 16'h0108);
        set_ex(1'b1, 3'd2, 16'hBEEF, 1'b1);
        step("loaduse");
        chk("loaduse.bubble_lit", 32'(bus.valid_o), 32'h0);
        set_ex(1'b0, 3'd0, 16'h0, 1'b0);
        set_mem(1'b1, 3'd2, 16'h0077);
        step("loaduse.mem");
`ifdef ID_FWD_EN
        chk("loaduse.mem.op1_lit", 32'(bus.operand1_o), 32'h0077);
`else
        chk("loaduse.mem.bubble_lit", 32'(bus.valid_o), 32'h0);
`endif
        set_mem(1'b0, 3'd0, 16'h0);
        step("loaduse.clear");
        chk("loaduse.clear.valid_lit", 32'(bus.valid_o), 32'h1);

        // Unknown RRR func, and invalid instruction with a would-be hazard
        set_inst(1'b1, 16'hE14C, 16'h010A);
        step("unknown");
        chk("unknown.wreg_lit", 32'(bus.wReg_o), 32'h0);
        set_inst(1'b0, 16'h4A25, 16'h010C);
        set_ex(1'b1, 3'd2, 16'h1234, 1'b1);
        step("invalid");
        set_ex(1'b0, 3'd0, 16'h0, 1'b0);

        // Hold under stall_i for 3 cycles, then flush wins over stall
        set_inst(1'b1, 16'h4380, 16'h0110);
        step("hold.load");
        bus.stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_inst(1'b1, 16'h6A00 + 16'(i), 16'(16'h0200 + i));
            step("hold");
            chk("hold.op2_lit", 32'(bus.operand2_o), 32'hFF80);
            chk("hold.waddr_lit", 32'(bus.wRegAddr_o), 32'h3);
        end
        bus.flush_i = 1'b1;
        step("flushstall");
        chk("flushstall.valid_lit", 32'(bus.valid_o), 32'h0);
        chk("flushstall.wreg_lit", 32'(bus.wReg_o), 32'h0);
        idle();

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) rf[$urandom_range(0, 7)] = 16'($urandom);
            case ($urandom_range(0, 5))
                0:       ins = {5'b01001, 11'($urandom)};
                1:       ins = {5'b01000, 11'($urandom)};
                2:       ins = {5'b01101, 11'($urandom)};
                3:       ins = {5'b11100, 11'($urandom)};
                4:       ins = 16'h0800;
                default: ins = 16'($urandom);
            endcase
            set_inst(1'($urandom_range(0, 7) != 0), ins, 16'($urandom));
            set_ex(1'($urandom_range(0, 1)), 3'($urandom), 16'($urandom), 1'($urandom_range(0, 2) == 0));
            set_mem(1'($urandom_range(0, 1)), 3'($urandom), 16'($urandom));
            bus.stall_i = ($urandom_range(0, 6) == 0);
            bus.flush_i = ($urandom_range(0, 9) == 0);
            step("rand");
            if (i == 200) begin
                mid_reset();
                idle();
                set_inst(1'b1, 16'h6C42, 16'h0300);
                step("afterreset");
                chk("afterreset.op1_lit", 32'(bus.operand1_o), 32'h0042);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
